// File: rtl/b2xx_reset_sequencer.sv
// Lock-qualified reset sequencer: holds every domain in reset until the
// clock source has been stable, then releases domains one by one.
module b2xx_reset_sequencer #(
  parameter int NUM_DOMAINS   = 3,
  parameter int HOLDOFF_WIDTH = 16,
  parameter int STAGE_GAP     = 256,
  parameter int DEBOUNCE      = 4,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                   bus_clk,
  input  logic                   bus_rst,
  input  logic                   locked,
  input  logic                   soft_rst_req,
  input  logic                   clear_count,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   ready,
  output logic [CNT_WIDTH-1:0]   lock_loss_count,
  output logic [1:0]             state
);

  localparam int GAP_W = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int LOW_W = $clog2(DEBOUNCE + 1);

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } seq_state_t;

  seq_state_t               state_q, state_d;
  logic [1:0]               sync_q;
  logic                     locked_s;
  logic [NUM_DOMAINS-1:0]   rst_q, rst_d;
  logic                     ready_q, ready_d;
  logic [HOLDOFF_WIDTH-1:0] hold_q, hold_d;
  logic [GAP_W-1:0]         gap_q, gap_d;
  logic [LOW_W-1:0]         low_q, low_d;
  logic [CNT_WIDTH-1:0]     cnt_q, cnt_d;
  logic                     fault;

  assign locked_s = sync_q[1];

  always_ff @(posedge bus_clk) begin
    if (bus_rst) begin
      sync_q  <= '0;
      state_q <= HOLD;
      rst_q   <= '1;
      ready_q <= 1'b0;
      hold_q  <= '0;
      gap_q   <= '0;
      low_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], locked};
      state_q <= state_d;
      rst_q   <= rst_d;
      ready_q <= ready_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      low_q   <= low_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rst_d   = rst_q;
    ready_d = ready_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    low_d   = low_q;
    cnt_d   = cnt_q;
    fault   = 1'b0;

    if (clear_count)
      cnt_d = '0;

    unique case (state_q)
      HOLD: begin
        rst_d   = '1;
        ready_d = 1'b0;
        gap_d   = '0;
        low_d   = '0;
        if (!locked_s) begin
          hold_d = '0;
        end else if (hold_q == '1) begin
          state_d = RELEASE;
          rst_d   = ~NUM_DOMAINS'(1);
          hold_d  = '0;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      RELEASE, RUN: begin
        if (locked_s)
          low_d = '0;
        else if (low_q == LOW_W'(DEBOUNCE - 1))
          fault = 1'b1;
        else
          low_d = low_q + 1'b1;

        // Release one more domain per gap; ready follows one gap after the last
        if (state_q == RELEASE) begin
          if (gap_q == GAP_W'(STAGE_GAP - 1)) begin
            gap_d = '0;
            if (rst_q == '0) begin
              state_d = RUN;
              ready_d = 1'b1;
            end else begin
              rst_d = rst_q << 1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      default: state_d = HOLD;
    endcase

    if (fault) begin
      if (clear_count)
        cnt_d = CNT_WIDTH'(1);
      else if (cnt_q != '1)
        cnt_d = cnt_q + 1'b1;
    end

    if (fault || soft_rst_req) begin
      state_d = HOLD;
      rst_d   = '1;
      ready_d = 1'b0;
      hold_d  = '0;
      gap_d   = '0;
      low_d   = '0;
    end
  end

  assign rst_out         = rst_q;
  assign ready           = ready_q;
  assign lock_loss_count = cnt_q;
  assign state           = state_q;

endmodule
